// File: rtl/fifo_demo_pkg.sv
// Shared definitions for the asymmetric-width FIFO demo: FSM encoding,
// generator start value and the packed expected-word helper.
package fifo_demo_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_FILL   = ST_FILL,
    S_STREAM = ST_STREAM,
    S_HALT   = ST_HALT
  } state_e;

  localparam logic [15:0] START_VALUE_DEF = 16'h0001;

  // {e, e+1} with both halves kept modulo 2^hw; callers truncate to 2*hw bits.
  function automatic logic [63:0] pack_exp(input logic [63:0] e, input int hw);
    logic [63:0] mask;
    mask = (64'd1 << hw) - 64'd1;
    return ((e & mask) << hw) | ((e + 64'd1) & mask);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clear_i)                         count_q <= '0;
    else if (inc_i && (count_q != '1))   count_q <= count_q + WIDTH'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-side traffic engine: waits for the FIFO to fill, drains it and checks
// every returned word against the packed incrementing generator sequence.
module fifo_rd_checker
  import fifo_demo_pkg::*;
#(
  parameter int                    HALF_WIDTH    = 16,
  parameter logic [HALF_WIDTH-1:0] START_VALUE   = HALF_WIDTH'(START_VALUE_DEF),
  parameter int                    CNT_WIDTH     = 32,
  parameter bit                    STOP_ON_ERROR = 1'b0,
  parameter bit                    RESYNC        = 1'b0
) (
  input  logic                    rd_clk,
  input  logic                    sys_rst_n,
  input  logic                    enable_i,
  input  logic                    rst_busy_i,
  input  logic                    prog_full_i,
  input  logic                    empty_i,
  output logic                    rd_en_o,
  input  logic [2*HALF_WIDTH-1:0] rdata_i,
  input  logic                    rd_valid_i,
  output logic                    error_o,
  output logic [CNT_WIDTH-1:0]    word_cnt_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o,
  output logic [2*HALF_WIDTH-1:0] first_err_data_o,
  output logic [2*HALF_WIDTH-1:0] first_err_exp_o,
  output logic [1:0]              state_o
);

  localparam int DW = 2 * HALF_WIDTH;

  state_e                state_q;
  logic                  error_q;
  logic [HALF_WIDTH-1:0] exp_q, exp_d;
  logic [DW-1:0]         fd_q, fe_q;
  logic [DW-1:0]         exp_word;
  logic                  mism, cap;

  assign exp_word = DW'(pack_exp(64'(exp_q), HALF_WIDTH));
  assign mism     = rd_valid_i && (rdata_i != exp_word);
  assign cap      = mism && (err_cnt_o == '0);

  // Words arriving outside STREAM (read latency tail) still advance the check.
  always_comb begin
    exp_d = exp_q;
    if (rd_valid_i)
      exp_d = (RESYNC && mism) ? rdata_i[HALF_WIDTH-1:0] + HALF_WIDTH'(1)
                               : exp_q + HALF_WIDTH'(2);
  end

  always_ff @(posedge rd_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
      exp_q   <= START_VALUE;
      fd_q    <= '0;
      fe_q    <= '0;
    end else begin
      exp_q <= exp_d;
      if (mism) error_q <= 1'b1;
      if (cap) begin
        fd_q <= rdata_i;
        fe_q <= exp_word;
      end
      case (state_q)
        S_IDLE:   if (!rst_busy_i) state_q <= S_FILL;
        S_FILL:   if (prog_full_i) state_q <= S_STREAM;
        S_STREAM: if (mism && STOP_ON_ERROR) state_q <= S_HALT;
                  else if (rst_busy_i)       state_q <= S_IDLE;
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
    .clk_i   (rd_clk),
    .clear_i (~sys_rst_n),
    .inc_i   (rd_valid_i),
    .count_o (word_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk_i   (rd_clk),
    .clear_i (~sys_rst_n),
    .inc_i   (mism),
    .count_o (err_cnt_o)
  );

  assign rd_en_o          = (state_q == S_STREAM) & enable_i & ~empty_i;
  assign error_o          = error_q;
  assign first_err_data_o = fd_q;
  assign first_err_exp_o  = fe_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench: three checker configurations share one FIFO model and are compared
// every cycle against a per-configuration reference of the read rules.
module tb_fifo_rd_checker;

  localparam int N = 3;
  localparam logic [15:0] CFG_START [N] = '{16'h0001, 16'h0001, 16'hFFFD};
  localparam bit          CFG_STOP  [N] = '{1'b0, 1'b1, 1'b0};
  localparam bit          CFG_RS    [N] = '{1'b0, 1'b1, 1'b0};
  localparam longint      CFG_MAX   [N] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};

  logic clk;
  logic rst_n, en, busy, pf, empty, valid;
  logic [31:0] data;

  logic [N-1:0]       rd_en, err;
  logic [N-1:0][1:0]  st;
  logic [N-1:0][31:0] wc, ec, fd, fe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g == 1) ? 4 : 32;
    logic [CW-1:0] wcl, ecl;
    fifo_rd_checker #(
      .HALF_WIDTH(16), .START_VALUE(CFG_START[g]), .CNT_WIDTH(CW),
      .STOP_ON_ERROR(CFG_STOP[g]), .RESYNC(CFG_RS[g])
    ) u_dut (
      .rd_clk(clk), .sys_rst_n(rst_n), .enable_i(en), .rst_busy_i(busy),
      .prog_full_i(pf), .empty_i(empty), .rd_en_o(rd_en[g]),
      .rdata_i(data), .rd_valid_i(valid), .error_o(err[g]),
      .word_cnt_o(wcl), .err_cnt_o(ecl),
      .first_err_data_o(fd[g]), .first_err_exp_o(fe[g]), .state_o(st[g])
    );
    assign wc[g] = 32'(wcl);
    assign ec[g] = 32'(ecl);
  end

  int checks = 0;
  int fails  = 0;

  int          m_st  [N];
  logic [15:0] m_exp [N];
  longint      m_wc  [N], m_ec [N];
  bit          m_err [N];
  logic [31:0] m_fd  [N], m_fe [N];

  logic [31:0] fifo[$];
  logic [15:0] nxt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ex);
    checks++;
    assert (obs === ex) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic mreset(input int i);
    m_st[i] = 0; m_exp[i] = CFG_START[i]; m_wc[i] = 0; m_ec[i] = 0;
    m_err[i] = 1'b0; m_fd[i] = '0; m_fe[i] = '0;
  endtask

  task automatic push_seq(input int n);
    for (int k = 0; k < n; k++) begin
      fifo.push_back({nxt, nxt + 16'd1});
      nxt = nxt + 16'd2;
    end
  endtask

  // One clock: check read enable mid-cycle, advance the model, check registers.
  task automatic cycle();
    bit pop, exp_rd, mm;
    logic [31:0] ew;
    empty = (fifo.size() == 0);
    @(negedge clk);
    pop = (m_st[0] == 2) && en && !empty;
    for (int i = 0; i < N; i++) begin
      exp_rd = (m_st[i] == 2) && en && !empty;
      chk($sformatf("rd_en%0d", i), 64'(rd_en[i]), 64'(exp_rd));
      if (!rst_n) mreset(i);
      else begin
        ew = {m_exp[i], m_exp[i] + 16'd1};
        mm = valid && (data !== ew);
        if (valid) begin
          if (m_wc[i] < CFG_MAX[i]) m_wc[i]++;
          m_exp[i] = (CFG_RS[i] && mm) ? data[15:0] + 16'd1 : m_exp[i] + 16'd2;
        end
        if (mm) begin
          if (m_ec[i] == 0) begin m_fd[i] = data; m_fe[i] = ew; end
          if (m_ec[i] < CFG_MAX[i]) m_ec[i]++;
          m_err[i] = 1'b1;
        end
        case (m_st[i])
          0: if (!busy) m_st[i] = 1;
          1: if (pf) m_st[i] = 2;
          2: if (mm && CFG_STOP[i]) m_st[i] = 3; else if (busy) m_st[i] = 0;
          default: ;
        endcase
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("state%0d", i), 64'(st[i]), 64'(m_st[i]));
      chk($sformatf("error%0d", i), 64'(err[i]), 64'(m_err[i]));
      chk($sformatf("wcnt%0d", i), 64'(wc[i]), 64'(m_wc[i]));
      chk($sformatf("ecnt%0d", i), 64'(ec[i]), 64'(m_ec[i]));
      chk($sformatf("fdata%0d", i), 64'(fd[i]), 64'(m_fd[i]));
      chk($sformatf("fexp%0d", i), 64'(fe[i]), 64'(m_fe[i]));
    end
    if (pop) begin valid = 1'b1; data = fifo.pop_front(); end
    else     begin valid = 1'b0; data = $urandom; end
  endtask

  task automatic drain();
    for (int k = 0; k < 80; k++) begin
      if (fifo.size() == 0 && !valid) break;
      en = ($urandom % 4) != 0;
      cycle();
    end
    chk("drain_bound", 64'(fifo.size()) + 64'(valid), 64'd0);
    en = 1'b1;
  endtask

  task automatic restart();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; busy = 1'b0; cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; busy = 1'b1; pf = 1'b0; en = 1'b1; valid = 1'b0; data = '0;
    empty = 1'b1; nxt = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) mreset(i);

    // reset held one more checked cycle, then FIFO reset-busy for 10 cycles
    cycle();
    rst_n = 1'b1;
    repeat (10) cycle();
    busy = 1'b0;
    repeat (5) cycle();
    chk("t1_state", 64'(st[0]), 64'd1);
    chk("t1_wcnt", 64'(wc[0]), 64'd0);

    // basic stream of three words
    push_seq(3);
    cycle();
    pf = 1'b1; cycle(); pf = 1'b0;
    drain();
    chk("t2_wcnt", 64'(wc[0]), 64'd3);
    chk("t2_ecnt", 64'(ec[0]), 64'd0);
    chk("t2_err", 64'(err[0]), 64'd0);

    // wrap-around sequence against the FFFD-start instance
    restart();
    nxt = 16'hFFFD; push_seq(3);
    pf = 1'b1; cycle(); pf = 1'b0;
    drain();
    chk("t3_err", 64'(err[2]), 64'd0);
    chk("t3_wcnt", 64'(wc[2]), 64'd3);

    // corrupted third word, then a good continuation
    restart();
    fifo.push_back(32'h0001_0002); fifo.push_back(32'h0003_0004);
    fifo.push_back(32'h0005_0007); fifo.push_back(32'h0007_0008);
    nxt = 16'h0009;
    pf = 1'b1; cycle(); pf = 1'b0;
    drain();
    chk("t4_err", 64'(err[0]), 64'd1);
    chk("t4_ecnt", 64'(ec[0]), 64'd1);
    chk("t4_fdata", 64'(fd[0]), 64'h0005_0007);
    chk("t4_fexp", 64'(fe[0]), 64'h0005_0006);
    chk("t5_state", 64'(st[1]), 64'd3);
    chk("t5_wcnt", 64'(wc[1]), 64'd4);

    // random traffic with sparse bit flips; halted instance keeps counting
    for (int k = 0; k < 20; k++) begin
      w = {nxt, nxt + 16'd1};
      nxt = nxt + 16'd2;
      if ($urandom % 5 == 0) w = w ^ (32'd1 << $urandom_range(31, 0));
      fifo.push_back(w);
    end
    drain();
    chk("sat_wcnt", 64'(wc[1]), 64'd15);
    chk("halt_rden", 64'(rd_en[1]), 64'd0);

    // pause mid-stream, then reset mid-burst
    push_seq(6);
    cycle(); cycle();
    en = 1'b0; cycle();
    chk("t6_pause_rden", 64'(rd_en[0]), 64'd0);
    chk("t6_pause_state", 64'(st[0]), 64'd2);
    en = 1'b1; cycle();
    rst_n = 1'b0; cycle();
    chk("t6_rst_state", 64'(st[0]), 64'd0);
    chk("t6_rst_rden", 64'(rd_en[0]), 64'd0);
    chk("t6_rst_wcnt", 64'(wc[0]), 64'd0);
    chk("t6_rst_err", 64'(err[0]), 64'd0);
    chk("t6_rst_fdata", 64'(fd[0]), 64'd0);

    // reset-busy rising while streaming returns to IDLE
    rst_n = 1'b1; busy = 1'b0; cycle();
    pf = 1'b1; cycle(); pf = 1'b0;
    cycle();
    busy = 1'b1; cycle();
    chk("busy_idle", 64'(st[0]), 64'd0);
    busy = 1'b0;
    fifo.delete();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
